// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the main-memory arbiter and its latency counter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } arb_state_e;

    localparam logic REQ_I = 1'b0;
    localparam logic REQ_D = 1'b1;

    localparam int ADDR_W_DEF  = 10;
    localparam int DATA_W_DEF  = 32;
    localparam int MEM_LAT_DEF = 4;
    localparam int CNT_W       = 4;

    // Counter preload for a given latency; ACCESS lasts lat cycles.
    function automatic logic [CNT_W-1:0] lat_preload(input int lat);
        return CNT_W'(lat - 1);
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between both cache controllers, the memory array and mem_arbiter.
interface mem_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) ();

    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_done;
    logic [DATA_W-1:0] i_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_done;
    logic [DATA_W-1:0] d_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output i_done, i_rdata, d_done, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  i_done, i_rdata, d_done, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, busy
    );

endinterface

// File: rtl/mem_lat_counter.sv
// Loadable down-counter with zero flag; holds at zero, load has priority over decrement.
module mem_lat_counter
    import mem_arb_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign zero = (cnt_q == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Serializes I-cache and D-cache accesses to the single-ported main memory.
// MEM_ARB_ROUND_ROBIN_EN selects round-robin tie-breaking instead of fixed data priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int MEM_LAT = MEM_LAT_DEF
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus
);

    arb_state_e        state_q, state_d;
    logic              id_q, id_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic              last_q, last_d;
`endif

    logic             grant_id;
    logic             cnt_load;
    logic             cnt_dec;
    logic [CNT_W-1:0] lat_cnt;
    logic             lat_zero;

    mem_lat_counter #(.W(CNT_W)) u_lat_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (lat_preload(MEM_LAT)),
        .dec      (cnt_dec),
        .cnt      (lat_cnt),
        .zero     (lat_zero)
    );

    always_comb begin
        grant_id = REQ_I;
        if (bus.d_req && bus.i_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            grant_id = (last_q == REQ_I) ? REQ_D : REQ_I;
`else
            grant_id = REQ_D;
`endif
        end else if (bus.d_req) begin
            grant_id = REQ_D;
        end
    end

    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        last_d    = last_q;
`endif
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.i_req || bus.d_req) begin
                    state_d  = ACCESS;
                    id_d     = grant_id;
                    we_d     = (grant_id == REQ_D) && bus.d_we;
                    addr_d   = (grant_id == REQ_D) ? bus.d_addr : bus.i_addr;
                    wdata_d  = (grant_id == REQ_D) ? bus.d_wdata : '0;
                    cnt_load = 1'b1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    last_d   = grant_id;
`endif
                end
            end
            ACCESS: begin
                cnt_dec = (lat_cnt != '0);
                if (lat_zero) begin
                    // mem_rdata is only valid in this last ACCESS cycle.
                    if (!we_q) begin
                        if (id_q == REQ_D) begin
                            d_rdata_d = bus.mem_rdata;
                        end else begin
                            i_rdata_d = bus.mem_rdata;
                        end
                    end
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            id_q      <= REQ_I;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_q    <= REQ_I;
`endif
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_q    <= last_d;
`endif
        end
    end

    // Strobes decode registered state only, so they drop with async reset.
    assign bus.mem_en    = (state_q == ACCESS);
    assign bus.mem_we    = (state_q == ACCESS) && we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.i_done    = (state_q == RESP) && (id_q == REQ_I);
    assign bus.d_done    = (state_q == RESP) && (id_q == REQ_D);
    assign bus.i_rdata   = i_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with MEM_LAT = 4.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic clk;
    logic reset;

    int n_chk;
    int n_fail;

    int          en_cnt, we_cnt, idone_cnt, ddone_cnt, idone_at, ddone_at, hold_err;
    logic [9:0]  a0;
    logic [31:0] w0;

    mem_arbiter_if #(.ADDR_W(10), .DATA_W(32)) bus ();

    mem_arbiter #(.ADDR_W(10), .DATA_W(32), .MEM_LAT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Memory model: one fixed word at 0x08C, otherwise a pattern carrying the address.
    function automatic logic [31:0] mem_model(input logic [9:0] a);
        if (a == 10'h08C) return 32'hDEADBEEF;
        return {16'hA5C3, 6'h00, a};
    endfunction

    assign bus.mem_rdata = mem_model(bus.mem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Samples n negedges after stimulus; requesters drop req in their done cycle.
    task automatic watch(input int n, input int drop_at);
        logic prev_en;
        en_cnt = 0; we_cnt = 0; idone_cnt = 0; ddone_cnt = 0;
        idone_at = -1; ddone_at = -1; hold_err = 0; prev_en = 1'b0;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            if (bus.mem_en) begin
                if (!prev_en) begin
                    a0 = bus.mem_addr;
                    w0 = bus.mem_wdata;
                end else if (bus.mem_addr != a0 || bus.mem_wdata != w0) begin
                    hold_err++;
                end
                en_cnt++;
            end
            prev_en = bus.mem_en;
            if (bus.mem_we) we_cnt++;
            if (bus.i_done) begin
                idone_cnt++;
                if (idone_at < 0) idone_at = k;
                bus.i_req = 1'b0;
            end
            if (bus.d_done) begin
                ddone_cnt++;
                if (ddone_at < 0) ddone_at = k;
                bus.d_req = 1'b0;
            end
            if (k == drop_at) begin
                bus.i_req = 1'b0;
                bus.d_req = 1'b0;
            end
        end
    endtask

    task automatic rr_test();
        int g;
        int times[4];
        logic [3:0] seq;
        logic [3:0] exp_seq;
        g = 0;
        seq = 4'b0000;
        for (int i = 0; i < 4; i++) times[i] = 0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        exp_seq = 4'b0101;
`else
        exp_seq = 4'b1111;
`endif
        bus.d_we   = 1'b0;
        bus.d_addr = 10'h100;
        bus.i_addr = 10'h08C;
        bus.i_req  = 1'b1;
        bus.d_req  = 1'b1;
        for (int k = 1; k <= 40 && g < 4; k++) begin
            @(negedge clk);
            if (bus.d_done) begin
                seq[g] = REQ_D; times[g] = k; g++; bus.d_req = 1'b0;
            end else if (bus.i_done) begin
                seq[g] = REQ_I; times[g] = k; g++; bus.i_req = 1'b0;
            end else begin
                bus.d_req = 1'b1;
                bus.i_req = 1'b1;
            end
        end
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        check_eq("rr_grants", 64'(g), 64'd4);
        check_eq("rr_order", 64'(seq), 64'(exp_seq));
        check_eq("rr_gap01", 64'(times[1] - times[0]), 64'd6);
        check_eq("rr_gap23", 64'(times[3] - times[2]), 64'd6);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        n_chk = 0; n_fail = 0;
        reset = 1'b1;
        bus.i_req = 1'b0; bus.i_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;

        repeat (2) @(negedge clk);
        check_eq("rst_busy",    64'(bus.busy),    64'd0);
        check_eq("rst_mem_en",  64'(bus.mem_en),  64'd0);
        check_eq("rst_done",    64'({bus.i_done, bus.d_done}), 64'd0);
        check_eq("rst_rdata",   64'({bus.i_rdata, bus.d_rdata}), 64'd0);
        check_eq("rst_addr",    64'(bus.mem_addr), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Simultaneous requests: data first, instruction granted after one IDLE cycle.
        bus.i_addr = 10'h200; bus.d_addr = 10'h100; bus.d_we = 1'b0;
        bus.i_req = 1'b1; bus.d_req = 1'b1;
        watch(14, 0);
        check_eq("tie_d_at",   64'(ddone_at),  64'd5);
        check_eq("tie_i_at",   64'(idone_at),  64'd11);
        check_eq("tie_counts", 64'({idone_cnt[7:0], ddone_cnt[7:0]}), 64'h0101);
        check_eq("tie_en",     64'(en_cnt),    64'd8);
        check_eq("tie_d_rd",   64'(bus.d_rdata), 64'hA5C30100);
        check_eq("tie_i_rd",   64'(bus.i_rdata), 64'hA5C30200);

        // Single instruction read.
        bus.i_addr = 10'h08C; bus.i_req = 1'b1;
        watch(7, 0);
        check_eq("i_en_cnt",  64'(en_cnt),    64'd4);
        check_eq("i_we_cnt",  64'(we_cnt),    64'd0);
        check_eq("i_addr",    64'(a0),        64'h08C);
        check_eq("i_done_at", 64'(idone_at),  64'd5);
        check_eq("i_done_n",  64'(idone_cnt), 64'd1);
        check_eq("i_no_d",    64'(ddone_cnt), 64'd0);
        check_eq("i_rdata",   64'(bus.i_rdata), 64'hDEADBEEF);
        check_eq("i_idle",    64'(bus.busy),  64'd0);

        rr_test();

        // Write-through store.
        bus.d_we = 1'b1; bus.d_addr = 10'h3FC; bus.d_wdata = 32'h12345678; bus.d_req = 1'b1;
        watch(7, 0);
        check_eq("st_en_cnt",  64'(en_cnt),   64'd4);
        check_eq("st_we_cnt",  64'(we_cnt),   64'd4);
        check_eq("st_addr",    64'(a0),       64'h3FC);
        check_eq("st_wdata",   64'(w0),       64'h12345678);
        check_eq("st_hold",    64'(hold_err), 64'd0);
        check_eq("st_done_at", 64'(ddone_at), 64'd5);
        check_eq("st_no_i",    64'(idone_cnt), 64'd0);
        check_eq("st_d_rdata", 64'(bus.d_rdata), 64'hA5C30100);
        check_eq("st_i_rdata", 64'(bus.i_rdata), 64'hDEADBEEF);
        bus.d_we = 1'b0;

        // Reset in the 2nd ACCESS cycle of a data read.
        bus.d_addr = 10'h044; bus.d_req = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("pre_rst_en", 64'(bus.mem_en), 64'd1);
        reset = 1'b1;
        bus.d_req = 1'b0;
        #1;
        check_eq("arst_en",    64'({bus.mem_en, bus.mem_we}), 64'd0);
        check_eq("arst_busy",  64'(bus.busy), 64'd0);
        check_eq("arst_rdata", 64'({bus.i_rdata, bus.d_rdata}), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        watch(6, 0);
        check_eq("arst_no_done", 64'(idone_cnt + ddone_cnt), 64'd0);
        check_eq("arst_no_en",   64'(en_cnt), 64'd0);
        bus.i_addr = 10'h08C; bus.i_req = 1'b1;
        watch(7, 0);
        check_eq("post_rst_at", 64'(idone_at), 64'd5);
        check_eq("post_rst_rd", 64'(bus.i_rdata), 64'hDEADBEEF);

        // Request withdrawn during ACCESS still completes.
        bus.i_addr = 10'h2A0; bus.i_req = 1'b1;
        watch(7, 1);
        check_eq("drop_en",    64'(en_cnt),    64'd4);
        check_eq("drop_at",    64'(idone_at),  64'd5);
        check_eq("drop_n",     64'(idone_cnt), 64'd1);
        check_eq("drop_rdata", 64'(bus.i_rdata), 64'hA5C302A0);
        check_eq("drop_idle",  64'(bus.busy),  64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
